// File: rtl/ddr3_app_pkg.sv
// ddr3_app_pkg: shared MIG app-interface constants and write-controller state encoding
package ddr3_app_pkg;
  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;
  localparam int ADDR_STEP = 8;
  localparam int DATA_W = 256;
  localparam int ADDR_W = 28;
  typedef enum logic [1:0] {IDLE, LOAD, BURST, DONE} state_t;
endpackage

// File: rtl/ddr3_wr_burst_ctrl.sv
// ddr3_wr_burst_ctrl: pops one write command, streams its commands and data to the MIG app port
module ddr3_wr_burst_ctrl import ddr3_app_pkg::*; #(
  parameter int DATA_W = ddr3_app_pkg::DATA_W,
  parameter int ADDR_W = ddr3_app_pkg::ADDR_W,
  parameter int ADDR_STEP = ddr3_app_pkg::ADDR_STEP
) (
  input  logic                I_Clk,
  input  logic                I_Rst_n,
  input  logic                I_calib_done,
  input  logic                I_cmd_empty,
  input  logic [ADDR_W-1:0]   I_cmd_addr,
  input  logic [7:0]          I_cmd_bl,
  output logic                O_cmd_rden,
  input  logic                I_wdata_empty,
  input  logic [DATA_W-1:0]   I_wdata,
  output logic                O_wdata_rden,
  output logic                O_app_en,
  output logic [2:0]          O_app_cmd,
  output logic [ADDR_W-1:0]   O_app_addr,
  input  logic                I_app_rdy,
  output logic                O_app_wdf_wren,
  output logic                O_app_wdf_end,
  output logic [DATA_W-1:0]   O_app_wdf_data,
  output logic [DATA_W/8-1:0] O_app_wdf_mask,
  input  logic                I_app_wdf_rdy,
  output logic                O_busy,
  output logic                O_done
);
  state_t            r_state;
  logic              r_arm;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_bl, r_cmd_cnt, r_data_cnt;
  logic              w_burst;
  assign w_burst = r_state == BURST;
  // r_arm keeps the first cycle after reset release free of any FIFO pop
  assign O_cmd_rden = r_state == IDLE && r_arm && I_calib_done && !I_cmd_empty;
  assign O_app_en = w_burst && r_cmd_cnt < r_bl;
  assign O_app_cmd = APP_CMD_WR;
  assign O_app_addr = O_app_en ? r_addr + ADDR_W'(r_cmd_cnt) * ADDR_W'(ADDR_STEP) : '0;
  assign O_app_wdf_wren = w_burst && r_data_cnt < r_bl && !I_wdata_empty;
  assign O_app_wdf_end = O_app_wdf_wren;
  assign O_app_wdf_data = O_app_wdf_wren ? I_wdata : '0;
  assign O_app_wdf_mask = '0;
  assign O_wdata_rden = O_app_wdf_wren && I_app_wdf_rdy;
  assign O_busy = r_state != IDLE;
  assign O_done = r_state == DONE;
  always_ff @(posedge I_Clk or negedge I_Rst_n)
    if (!I_Rst_n) begin
      r_state <= IDLE;
      r_arm <= 1'b0;
      r_addr <= '0;
      r_bl <= '0;
      r_cmd_cnt <= '0;
      r_data_cnt <= '0;
    end else begin
      r_arm <= 1'b1;
      case (r_state)
        IDLE: if (O_cmd_rden) begin
          r_addr <= I_cmd_addr;
          r_bl <= I_cmd_bl;
          r_cmd_cnt <= '0;
          r_data_cnt <= '0;
          r_state <= LOAD;
        end
        LOAD: r_state <= r_bl == 8'd0 ? DONE : BURST;
        BURST: begin
          if (O_app_en && I_app_rdy) r_cmd_cnt <= r_cmd_cnt + 8'd1;
          if (O_wdata_rden) r_data_cnt <= r_data_cnt + 8'd1;
          if (r_cmd_cnt == r_bl && r_data_cnt == r_bl) r_state <= DONE;
        end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: doc/ddr3_wr_burst_ctrl.md
DDR3_WR_BURST_CTRL -- requirements
Module: ddr3_wr_burst_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 256, app data width (32-bit DQ x BL8).
REQ-002 SHALL have parameter ADDR_W, default 28, app address width.
REQ-003 SHALL have parameter ADDR_STEP, default 8, address increment per app command.
REQ-004 Clocking and reset SHALL be as follows: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port list (name, direction, width, meaning):
- I_Clk  in  1  MIG ui_clk; all logic on rising edge.
- I_Rst_n  in  1  async active-low reset.
- I_calib_done  in  1  MIG init_calib_complete.
- I_cmd_empty  in  1  write-cmd FIFO empty (FWFT).
- I_cmd_addr  in  ADDR_W  start address at cmd FIFO head.
- I_cmd_bl  in  8  beat count at cmd FIFO head.
- O_cmd_rden  out  1  cmd FIFO pop.
- I_wdata_empty  in  1  write-data FIFO empty (FWFT).
- I_wdata  in  DATA_W  data FIFO head word.
- O_wdata_rden  out  1  data FIFO pop.
- O_app_en / O_app_cmd / O_app_addr  out  1/3/ADDR_W  MIG command channel.
- I_app_rdy  in  1  MIG command accept.
- O_app_wdf_wren / O_app_wdf_end  out  1/1  MIG write-data valid / last.
- O_app_wdf_data  out  DATA_W  write data.
- O_app_wdf_mask  out  DATA_W/8  byte mask.
- I_app_wdf_rdy  in  1  MIG write-data accept.
- O_busy  out  1  burst in progress.
- O_done  out  1  one-cycle burst-complete pulse.

Function
REQ-006 SHALL implement states IDLE, LOAD, BURST, DONE.
REQ-007 IDLE->LOAD when I_calib_done=1 and I_cmd_empty=0; O_cmd_rden SHALL pulse for exactly that cycle, capturing I_cmd_addr and I_cmd_bl into registers.
REQ-008 While I_calib_done=0, SHALL remain in IDLE and never pop either FIFO.
REQ-009 LOAD->BURST next cycle if captured bl!=0; LOAD->DONE if bl==0, with no app traffic.
REQ-010 In BURST, O_app_en SHALL be 1 while cmd_cnt<bl; O_app_cmd=3'b000 (write) constant; O_app_addr=captured addr + cmd_cnt*ADDR_STEP, modulo 2^ADDR_W.
REQ-011 A command beat SHALL be counted only on O_app_en & I_app_rdy; O_app_en/O_app_addr SHALL hold while I_app_rdy=0.
REQ-012 In BURST, O_app_wdf_wren SHALL be 1 while data_cnt<bl and I_wdata_empty=0; O_app_wdf_data=I_wdata combinationally.
REQ-013 O_wdata_rden SHALL equal O_app_wdf_wren & I_app_wdf_rdy; data_cnt increments on the same condition.
REQ-014 O_app_wdf_end SHALL equal O_app_wdf_wren (BL8, one data word per command); O_app_wdf_mask SHALL be all zeros.
REQ-015 Command and data channels SHALL advance independently; data may lead commands by up to bl beats.
REQ-016 BURST->DONE in the cycle after both cmd_cnt==bl and data_cnt==bl; accepts landing in the same cycle on both channels SHALL both be counted.
REQ-017 DONE SHALL assert O_done for one cycle then return to IDLE; a queued command SHALL be popped no earlier than the cycle after DONE.
REQ-018 O_busy SHALL be 1 in LOAD, BURST, DONE; 0 in IDLE.
REQ-019 Counters SHALL be 8 bits; bl range 1..255; bl=0 is a no-op completion.

Reset
REQ-020 On I_Rst_n=0, state SHALL be IDLE and all outputs 0 immediately, including mid-burst; partial bursts are abandoned, not resumed.
REQ-021 Release SHALL be synchronised externally; block SHALL take no action in the first cycle after release.

Structure
REQ-022 Shared package ddr3_app_pkg SHALL hold APP_CMD_WR=3'b000, APP_CMD_RD=3'b001, ADDR_STEP, DATA_W, ADDR_W and the state enum.
REQ-023 Single module, no sub-modules; address is an adder on the captured base, not a free-running register.

Verification
REQ-024 bl=64, addr=0, rdy both tied 1, 64 words preloaded -> 64 app_en beats, addr 0..504 step 8, 64 wdf beats data 0..63, O_done once.
REQ-025 I_app_rdy toggled 1-of-3 cycles, bl=4, addr=0x100 -> addr/en held through stalls, addrs 0x100,0x108,0x110,0x118, no duplicates.
REQ-026 Data FIFO empty for 20 cycles after cmd pop, bl=8 -> 8 commands issued, wdf_wren 0 until data arrives, O_done only after 8th data beat.
REQ-027 addr=0xFFFFFF8, bl=3 -> app_addr 0xFFFFFF8, 0x0000000, 0x0000008.
REQ-028 bl=0 -> one O_cmd_rden, O_done 2 cycles later, zero app_en/wdf_wren.
REQ-029 Reset asserted at beat 10 of bl=64 -> all outputs 0 same cycle; after release with calib_done=1, next queued command processed from its own base address.
